// File: rtl/matmul_engine_if.sv
// matmul_engine_if: job handshake plus input/weight/result SRAM ports of the matmul engine.
interface matmul_engine_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic                  dut_valid;
    logic                  dut_ready;
    logic                  dut_error;
    logic [ADDR_WIDTH-1:0] dut__tb__sram_input_read_address;
    logic [DATA_WIDTH-1:0] tb__dut__sram_input_read_data;
    logic [ADDR_WIDTH-1:0] dut__tb__sram_weight_read_address;
    logic [DATA_WIDTH-1:0] tb__dut__sram_weight_read_data;
    logic                  dut__tb__sram_result_write_enable;
    logic [ADDR_WIDTH-1:0] dut__tb__sram_result_write_address;
    logic [DATA_WIDTH-1:0] dut__tb__sram_result_write_data;
    logic                  dut__tb__sram_input_write_enable;
    logic [ADDR_WIDTH-1:0] dut__tb__sram_input_write_address;
    logic [DATA_WIDTH-1:0] dut__tb__sram_input_write_data;
    logic                  dut__tb__sram_weight_write_enable;
    logic [ADDR_WIDTH-1:0] dut__tb__sram_weight_write_address;
    logic [DATA_WIDTH-1:0] dut__tb__sram_weight_write_data;
    logic [ADDR_WIDTH-1:0] dut__tb__sram_result_read_address;
    modport master (
        output dut_valid, tb__dut__sram_input_read_data, tb__dut__sram_weight_read_data,
        input  dut_ready, dut_error,
        input  dut__tb__sram_input_read_address, dut__tb__sram_weight_read_address,
        input  dut__tb__sram_result_write_enable, dut__tb__sram_result_write_address,
        input  dut__tb__sram_result_write_data,
        input  dut__tb__sram_input_write_enable, dut__tb__sram_input_write_address,
        input  dut__tb__sram_input_write_data,
        input  dut__tb__sram_weight_write_enable, dut__tb__sram_weight_write_address,
        input  dut__tb__sram_weight_write_data, dut__tb__sram_result_read_address
    );
    modport slave (
        input  dut_valid, tb__dut__sram_input_read_data, tb__dut__sram_weight_read_data,
        output dut_ready, dut_error,
        output dut__tb__sram_input_read_address, dut__tb__sram_weight_read_address,
        output dut__tb__sram_result_write_enable, dut__tb__sram_result_write_address,
        output dut__tb__sram_result_write_data,
        output dut__tb__sram_input_write_enable, dut__tb__sram_input_write_address,
        output dut__tb__sram_input_write_data,
        output dut__tb__sram_weight_write_enable, dut__tb__sram_weight_write_address,
        output dut__tb__sram_weight_write_data, dut__tb__sram_result_read_address
    );
endinterface

// File: rtl/matmul_engine.sv
// matmul_engine: signed C = A x B streamed from input/weight SRAMs into result SRAM.
// MATMUL_ENGINE_SATURATE_EN defined: results clamp to DATA_WIDTH signed range instead of wrapping.
module matmul_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int ACC_WIDTH  = 64
) (
    input logic           clk,
    input logic           reset,
    matmul_engine_if.slave bus
);
    localparam int H = DATA_WIDTH / 2;
    localparam logic [H-1:0] ONE = H'(1);
    localparam logic [63:0] LIM = (64'd1 << ADDR_WIDTH) - 64'd1;
    typedef enum logic [2:0] {IDLE, HDR, HCHK, MAC, LAST, WR, ERR, DONE} state_t;
    state_t state_q;
    logic ready_q, error_q, we_q;
    logic [ADDR_WIDTH-1:0] a_addr_q, b_addr_q, a_base_q, w_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q, res_d;
    logic [H-1:0] m_q, k_q, n_q, i_q, j_q, kc_q;
    logic [H-1:0] m_in, k_in, kb_in, n_in;
    logic [DATA_WIDTH-1:0] mk, kn, mn;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic accept, bad_range;
    always_comb begin
        {m_in, k_in} = bus.tb__dut__sram_input_read_data;
        {kb_in, n_in} = bus.tb__dut__sram_weight_read_data;
        mk = DATA_WIDTH'(m_in) * DATA_WIDTH'(k_in);
        kn = DATA_WIDTH'(kb_in) * DATA_WIDTH'(n_in);
        mn = DATA_WIDTH'(m_in) * DATA_WIDTH'(n_in);
        // highest A/B address is the element count; highest C address is one below it
        bad_range = 64'(mk) > LIM || 64'(kn) > LIM || 64'(mn) > LIM + 64'd1;
        prod = (2*DATA_WIDTH)'($signed(bus.tb__dut__sram_input_read_data)) *
               (2*DATA_WIDTH)'($signed(bus.tb__dut__sram_weight_read_data));
        acc_d = acc_q + ACC_WIDTH'(prod);
`ifdef MATMUL_ENGINE_SATURATE_EN
        res_d = (&acc_d[ACC_WIDTH-1:DATA_WIDTH-1] || ~|acc_d[ACC_WIDTH-1:DATA_WIDTH-1]) ?
                acc_d[DATA_WIDTH-1:0] : {acc_d[ACC_WIDTH-1], {(DATA_WIDTH-1){~acc_d[ACC_WIDTH-1]}}};
`else
        res_d = acc_d[DATA_WIDTH-1:0];
`endif
        accept = bus.dut_valid && ready_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            error_q <= 1'b0;
            we_q <= 1'b0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            a_base_q <= '0;
            w_addr_q <= '0;
            w_data_q <= '0;
            acc_q <= '0;
            m_q <= '0;
            k_q <= '0;
            n_q <= '0;
            i_q <= '0;
            j_q <= '0;
            kc_q <= '0;
        end else if (accept) begin
            state_q <= HDR;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            a_addr_q <= '0;
            b_addr_q <= '0;
        end else begin
            case (state_q)
                HDR: state_q <= HCHK;
                HCHK: begin
                    m_q <= m_in;
                    k_q <= k_in;
                    n_q <= n_in;
                    i_q <= '0;
                    j_q <= '0;
                    kc_q <= '0;
                    a_addr_q <= ADDR_WIDTH'(1);
                    b_addr_q <= ADDR_WIDTH'(1);
                    a_base_q <= ADDR_WIDTH'(1);
                    w_addr_q <= '0;
                    if (k_in != kb_in) begin
                        state_q <= ERR;
                        error_q <= 1'b1;
                        ready_q <= 1'b1;
                    end else if (m_in == '0 || k_in == '0 || n_in == '0) begin
                        state_q <= DONE;
                        ready_q <= 1'b1;
                    end else if (bad_range) begin
                        state_q <= ERR;
                        error_q <= 1'b1;
                        ready_q <= 1'b1;
                    end else state_q <= MAC;
                end
                MAC: begin
                    // read data in the k=0 cycle belongs to no product of this element
                    acc_q <= kc_q == '0 ? '0 : acc_d;
                    if (kc_q == k_q - ONE) state_q <= LAST;
                    else begin
                        kc_q <= kc_q + ONE;
                        a_addr_q <= a_addr_q + ADDR_WIDTH'(1);
                        b_addr_q <= b_addr_q + ADDR_WIDTH'(n_q);
                    end
                end
                LAST: begin
                    acc_q <= acc_d;
                    w_data_q <= res_d;
                    we_q <= 1'b1;
                    state_q <= WR;
                end
                WR: begin
                    we_q <= 1'b0;
                    w_addr_q <= w_addr_q + ADDR_WIDTH'(1);
                    kc_q <= '0;
                    if (j_q == n_q - ONE) begin
                        j_q <= '0;
                        i_q <= i_q + ONE;
                        a_base_q <= a_base_q + ADDR_WIDTH'(k_q);
                        a_addr_q <= a_base_q + ADDR_WIDTH'(k_q);
                        b_addr_q <= ADDR_WIDTH'(1);
                        state_q <= i_q + ONE == m_q ? DONE : MAC;
                        ready_q <= i_q + ONE == m_q;
                    end else begin
                        j_q <= j_q + ONE;
                        a_addr_q <= a_base_q;
                        b_addr_q <= ADDR_WIDTH'(j_q) + ADDR_WIDTH'(2);
                        state_q <= MAC;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.dut_ready = ready_q;
    assign bus.dut_error = error_q;
    assign bus.dut__tb__sram_input_read_address = a_addr_q;
    assign bus.dut__tb__sram_weight_read_address = b_addr_q;
    assign bus.dut__tb__sram_result_write_enable = we_q;
    assign bus.dut__tb__sram_result_write_address = w_addr_q;
    assign bus.dut__tb__sram_result_write_data = w_data_q;
    assign bus.dut__tb__sram_input_write_enable = 1'b0;
    assign bus.dut__tb__sram_input_write_address = '0;
    assign bus.dut__tb__sram_input_write_data = '0;
    assign bus.dut__tb__sram_weight_write_enable = 1'b0;
    assign bus.dut__tb__sram_weight_write_address = '0;
    assign bus.dut__tb__sram_weight_write_data = '0;
    assign bus.dut__tb__sram_result_read_address = '0;
endmodule

// File: tb/tb_matmul_engine.sv
// tb_matmul_engine: directed and random jobs checked against a plain-arithmetic matrix product model.
module tb_matmul_engine;
    localparam int DW = 32;
    localparam int AW = 12;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    matmul_engine_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    matmul_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(64)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    logic [DW-1:0] in_mem [0:4095];
    logic [DW-1:0] w_mem [0:4095];
    int a_v [256];
    int b_v [256];
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int c0 = 0;
    int wr_addr [$];
    int wr_cyc [$];
    logic [DW-1:0] wr_data [$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus.tb__dut__sram_input_read_data <= in_mem[bus.dut__tb__sram_input_read_address];
        bus.tb__dut__sram_weight_read_data <= w_mem[bus.dut__tb__sram_weight_read_address];
        if (bus.dut__tb__sram_result_write_enable === 1'b1) begin
            wr_addr.push_back(int'(bus.dut__tb__sram_result_write_address));
            wr_data.push_back(bus.dut__tb__sram_result_write_data);
            wr_cyc.push_back(cyc - c0);
        end
    end
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [31:0] model(input int m, input int k, input int n, input int i, input int j);
        longint s = 0;
        for (int t = 0; t < k; t++) s += longint'(a_v[i*k+t]) * longint'(b_v[t*n+j]);
`ifdef MATMUL_ENGINE_SATURATE_EN
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction
    task automatic load(input int m, input int k, input int kb, input int n);
        in_mem[0] = {m[15:0], k[15:0]};
        w_mem[0] = {kb[15:0], n[15:0]};
        for (int t = 0; t < m*k && t < 256; t++) in_mem[1+t] = a_v[t];
        for (int t = 0; t < kb*n && t < 256; t++) w_mem[1+t] = b_v[t];
    endtask
    task automatic run_job(input string tag, input int m, input int k, input int kb, input int n, input bit exp_err);
        int exp_w;
        int exp_r;
        exp_w = (exp_err || m == 0 || k == 0 || n == 0) ? 0 : m * n;
        exp_r = exp_w == 0 ? 3 : 3 + m * n * (k + 2);
        load(m, k, kb, n);
        @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        check({tag, ":ready_idle"}, bus.dut_ready, 1);
        bus.dut_valid = 1'b1;
        c0 = cyc;
        @(negedge clk);
        bus.dut_valid = 1'b0;
        check({tag, ":ready_busy"}, bus.dut_ready, 0);
        while (bus.dut_ready !== 1'b1 && cyc - c0 < 20000) begin
            bus.dut_valid = (cyc - c0 == 2);
            @(negedge clk);
        end
        bus.dut_valid = 1'b0;
        check({tag, ":ready_cycle"}, cyc - c0, exp_r);
        check({tag, ":error"}, bus.dut_error, exp_err);
        check({tag, ":n_writes"}, wr_addr.size(), exp_w);
        for (int t = 0; t < wr_addr.size() && t < exp_w; t++) begin
            check($sformatf("%s:addr[%0d]", tag, t), wr_addr[t], t);
            check($sformatf("%s:data[%0d]", tag, t), wr_data[t], model(m, k, n, t / n, t % n));
            check($sformatf("%s:wcyc[%0d]", tag, t), wr_cyc[t], k + 4 + t * (k + 2));
        end
    endtask
    task automatic randomize_ab(input int cnt);
        for (int t = 0; t < cnt; t++) begin
            a_v[t] = $urandom_range(0, 1) ? int'($urandom) : int'($urandom_range(0, 20)) - 10;
            b_v[t] = $urandom_range(0, 1) ? int'($urandom) : int'($urandom_range(0, 20)) - 10;
        end
    endtask
    initial begin
        int m, k, n;
        bus.dut_valid = 1'b0;
        for (int t = 0; t < 4096; t++) begin
            in_mem[t] = '0;
            w_mem[t] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst:ready", bus.dut_ready, 1);
        check("rst:error", bus.dut_error, 0);
        check("rst:we", bus.dut__tb__sram_result_write_enable, 0);
        check("rst:a_addr", bus.dut__tb__sram_input_read_address, 0);
        check("rst:b_addr", bus.dut__tb__sram_weight_read_address, 0);
        check("rst:w_addr", bus.dut__tb__sram_result_write_address, 0);
        check("rst:w_data", bus.dut__tb__sram_result_write_data, 0);
        reset = 1'b0;
        a_v[0:3] = '{1, 2, 3, 4};
        b_v[0:3] = '{1, 0, 0, 1};
        run_job("ident", 2, 2, 2, 2, 1'b0);
        a_v[0:2] = '{1, 2, 3};
        b_v[0:2] = '{4, 5, 6};
        run_job("dot", 1, 3, 3, 1, 1'b0);
        check("dot:value", wr_data.size() > 0 ? wr_data[0] : 32'hDEAD, 32);
        run_job("mismatch", 2, 3, 2, 2, 1'b1);
        run_job("m_zero", 0, 2, 2, 2, 1'b0);
        a_v[0:3] = '{5, -6, 7, 8};
        b_v[0:3] = '{-1, 2, 3, -4};
        run_job("after_zero", 2, 2, 2, 2, 1'b0);
        a_v[0] = 32'h7FFF_FFFF;
        b_v[0] = 2;
        run_job("overflow", 1, 1, 1, 1, 1'b0);
        run_job("range", 65, 1, 1, 64, 1'b1);
        for (int r = 0; r < 6; r++) begin
            m = $urandom_range(1, 4);
            k = $urandom_range(1, 4);
            n = $urandom_range(1, 4);
            randomize_ab(16);
            run_job($sformatf("rand%0d", r), m, k, k, n, 1'b0);
        end
        randomize_ab(16);
        load(4, 4, 4, 4);
        @(negedge clk);
        bus.dut_valid = 1'b1;
        @(negedge clk);
        bus.dut_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst:ready", bus.dut_ready, 1);
        check("midrst:we", bus.dut__tb__sram_result_write_enable, 0);
        check("midrst:a_addr", bus.dut__tb__sram_input_read_address, 0);
        check("midrst:w_addr", bus.dut__tb__sram_result_write_address, 0);
        reset = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        repeat (10) @(negedge clk);
        check("midrst:no_writes", wr_addr.size(), 0);
        randomize_ab(4);
        run_job("post_rst", 2, 2, 2, 2, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
